// File: rtl/fmdll_pkg.sv
// Shared FMDLL types and default constants for the divided-clock monitor.
package fmdll_pkg;

  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_TOL      = 1;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_ARM     = 2'd1,
    MON_MEASURE = 2'd2
  } mon_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop; flags a rising edge of an async input.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures the period of a divided clock in clk_ext cycles, checks it against
// an expected value and tracks lock / loss of lock.
module div_clk_monitor
  import fmdll_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned TOL      = DEF_TOL
) (
  input  logic             clk_ext,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             match,
  output logic             locked,
  output logic             lock_lost,
  output logic [7:0]       err_cnt
);

  localparam int unsigned       LC_W     = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [LC_W-1:0]   LOCK_TGT = LC_W'(LOCK_CNT);
  localparam logic [CNT_W:0]    TOL_X    = (CNT_W+1)'(TOL);
  localparam logic [7:0]        ERR_MAX  = 8'hFF;

  mon_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [LC_W-1:0]  mcnt, mcnt_nxt;
  logic             rise_c;
  logic             cmp_c, tmo_c, hit_c;
  logic [CNT_W-1:0] per_c;
  logic [CNT_W:0]   diff_c;

  sync_edge_det u_sync (
    .clk    (clk_ext),
    .rst    (rst),
    .d      (div_in),
    .rise_c (rise_c)
  );

  // An edge landing exactly at counter saturation reports all-ones rather than wrapping.
  assign per_c = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

  // Next-state and measurement control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmp_c     = 1'b0;
    tmo_c     = 1'b0;
    case (state)
      MON_IDLE: begin
        if (en) state_nxt = MON_ARM;
      end
      MON_ARM: begin
        if (rise_c) begin
          state_nxt = MON_MEASURE;
          cnt_nxt   = '0;
        end
      end
      MON_MEASURE: begin
        if (rise_c) begin
          cmp_c   = 1'b1;
          cnt_nxt = '0;
        end else if (cnt == CNT_MAX) begin
          cmp_c     = 1'b1;
          tmo_c     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = MON_ARM;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = MON_IDLE;
    endcase
    if (!en) begin
      state_nxt = MON_IDLE;
      cnt_nxt   = '0;
      cmp_c     = 1'b0;
      tmo_c     = 1'b0;
    end
  end

  // Absolute period error and lock counter update
  always_comb begin
    if (per_c >= exp_period) diff_c = {1'b0, per_c} - {1'b0, exp_period};
    else                     diff_c = {1'b0, exp_period} - {1'b0, per_c};
    hit_c    = ~tmo_c & (diff_c <= TOL_X);
    mcnt_nxt = mcnt;
    if (!en) begin
      mcnt_nxt = '0;
    end else if (cmp_c) begin
      if (!hit_c)                mcnt_nxt = '0;
      else if (mcnt != LOCK_TGT) mcnt_nxt = mcnt + LC_W'(1);
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state        <= MON_IDLE;
      cnt          <= '0;
      mcnt         <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      match        <= 1'b0;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mcnt         <= mcnt_nxt;
      locked       <= (mcnt_nxt == LOCK_TGT);
      period_valid <= cmp_c;
      lock_lost    <= cmp_c & ~hit_c & locked;
      if (cmp_c) begin
        period_out <= per_c;
        match      <= hit_c;
        if (!hit_c && err_cnt != ERR_MAX) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
